// File: rtl/core_alu_sched.sv
// Round-robin scheduler sharing one combinational ALU between N requesters, one op in flight.
// Optional macro CORE_ALU_SCHED_BYPASS_EN lets RESP hand off straight to the next ISSUE.
module core_alu_sched #(
    parameter int W   = 16,
    parameter int N   = 2,
    parameter int OPW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*OPW-1:0] req_op,
    input  logic [N*W-1:0]   req_a,
    input  logic [N*W-1:0]   req_b,
    output logic [N-1:0]     rsp_valid,
    input  logic [N-1:0]     rsp_ready,
    output logic [W-1:0]     rsp_q,
    output logic             alu_start,
    output logic [OPW-1:0]   alu_op,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    input  logic [W-1:0]     alu_q
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t         state;
    logic [IW-1:0]  grant;
    logic [IW-1:0]  last;
    logic [IW-1:0]  win;
    logic [IW-1:0]  idx;
    logic           found;
    logic           can_accept;
    logic           accept;

    logic [OPW-1:0] op_arr [N];
    logic [W-1:0]   a_arr  [N];
    logic [W-1:0]   b_arr  [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign op_arr[i] = req_op[i*OPW +: OPW];
        assign a_arr[i]  = req_a[i*W +: W];
        assign b_arr[i]  = req_b[i*W +: W];
    end

    // Search starts just past the previous winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last) + k) % N);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifdef CORE_ALU_SCHED_BYPASS_EN
    assign can_accept = (state == IDLE) || ((state == RESP) && rsp_ready[grant]);
`else
    assign can_accept = (state == IDLE);
`endif

    assign accept    = can_accept && found;
    assign req_ready = accept ? (N'(1) << win) : '0;

    // Operands are latched straight into the ALU drive registers, so they hold between ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            last      <= IW'(N - 1);
            alu_start <= 1'b0;
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_q     <= '0;
            rsp_valid <= '0;
        end else begin
            alu_start <= accept;
            if (accept) begin
                alu_op <= op_arr[win];
                alu_a  <= a_arr[win];
                alu_b  <= b_arr[win];
                grant  <= win;
                last   <= win;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_q     <= alu_q;
                    rsp_valid <= N'(1) << grant;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[grant]) begin
                        rsp_valid <= '0;
                        state     <= accept ? ISSUE : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_alu_sched.sv
// Self-checking bench for core_alu_sched: directed scenarios plus random traffic against a
// transaction-level model (busy flag, age since accept, round-robin pointer, expected result).
module tb_core_alu_sched;

    localparam int W   = 16;
    localparam int N   = 2;
    localparam int OPW = 3;

`ifdef CORE_ALU_SCHED_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_XOR = 3'd4;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*OPW-1:0] req_op;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ready;
    logic [W-1:0]     rsp_q;
    logic             alu_start;
    logic [OPW-1:0]   alu_op;
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [W-1:0]     alu_q;

    int checkCount;
    int failCount;
    int cycleCount;

    // Transaction-level reference state
    bit          busy;
    int          age;
    int          owner;
    int          rrLast;
    logic [2:0]  lastOp;
    logic [15:0] lastA;
    logic [15:0] lastB;
    logic [15:0] pendingResult;
    logic [15:0] shownResult;
    bit          measureGap;
    int          prevAccept;

    core_alu_sched #(.W(W), .N(N), .OPW(OPW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_q     (rsp_q),
        .alu_start (alu_start),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_q     (alu_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] aluRef(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << b[3:0];
            3'd6:    return a >> b[3:0];
            default: return b;
        endcase
    endfunction

    // Stand-in for the shared combinational ALU
    assign alu_q = aluRef(alu_op, alu_a, alu_b);

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cycleCount, observed, expected);
        end
    endtask

    task automatic modelReset();
        busy          = 1'b0;
        age           = 0;
        owner         = 0;
        rrLast        = N - 1;
        lastOp        = '0;
        lastA         = '0;
        lastB         = '0;
        pendingResult = '0;
        shownResult   = '0;
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        #1;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_alu_start", 32'(alu_start), 32'd0);
        checkOutput("rst_alu_op",    32'(alu_op),    32'd0);
        checkOutput("rst_alu_a",     32'(alu_a),     32'd0);
        checkOutput("rst_alu_b",     32'(alu_b),     32'd0);
        checkOutput("rst_rsp_q",     32'(rsp_q),     32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive inputs, compare every output with the model, then advance the model.
    task automatic applyStimulus(input logic [1:0] v, input logic [5:0] ops, input logic [31:0] as,
                                 input logic [31:0] bs, input logic [1:0] r);
        bit         respPhase;
        bit         free;
        bit         found;
        int         winner;
        int         idx;
        logic [1:0] expReady;
        @(negedge clk);
        req_valid = v;
        req_op    = ops;
        req_a     = as;
        req_b     = bs;
        rsp_ready = r;
        #1;
        respPhase = busy && (age >= 2);
        free      = !busy || (BYPASS && respPhase && r[owner]);
        found     = 1'b0;
        winner    = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (rrLast + k) % N;
            if (!found && v[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
        expReady = (free && found) ? 2'(1 << winner) : 2'b00;
        checkOutput("req_ready", 32'(req_ready), 32'(expReady));
        checkOutput("alu_start", 32'(alu_start), 32'(busy && (age == 1)));
        checkOutput("alu_op",    32'(alu_op),    32'(lastOp));
        checkOutput("alu_a",     32'(alu_a),     32'(lastA));
        checkOutput("alu_b",     32'(alu_b),     32'(lastB));
        checkOutput("rsp_valid", 32'(rsp_valid), respPhase ? 32'(1 << owner) : 32'd0);
        checkOutput("rsp_q",     32'(rsp_q),     32'(shownResult));
        if (measureGap && req_ready[0]) begin
            if (prevAccept >= 0)
                checkOutput("accept_gap", 32'(cycleCount - prevAccept), BYPASS ? 32'd2 : 32'd3);
            prevAccept = cycleCount;
        end
        if (busy && (age == 1)) shownResult = pendingResult;
        if (respPhase && r[owner]) busy = 1'b0;
        else if (busy)             age = 2;
        if (free && found) begin
            busy          = 1'b1;
            age           = 1;
            owner         = winner;
            rrLast        = winner;
            lastOp        = ops[winner*3 +: 3];
            lastA         = as[winner*16 +: 16];
            lastB         = bs[winner*16 +: 16];
            pendingResult = aluRef(lastOp, lastA, lastB);
        end
        cycleCount++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(2'b00, 6'd0, 32'd0, 32'd0, 2'b11);
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        cycleCount = 0;
        measureGap = 1'b0;
        prevAccept = -1;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = '0;
        modelReset();
        repeat (2) @(posedge clk);
        resetDut();

        $display("[TB] single op");
        applyStimulus(2'b01, {3'd0, ALU_ADD}, {16'h0, 16'h1234}, {16'h0, 16'h0001}, 2'b11);
        idleCycles(4);

        $display("[TB] round robin");
        for (int i = 0; i < 12; i++)
            applyStimulus(2'b11, {ALU_XOR, ALU_SUB}, {16'hFF00, 16'd5}, {16'h0FF0, 16'd3}, 2'b11);
        idleCycles(3);

        $display("[TB] back-pressure");
        applyStimulus(2'b11, {ALU_XOR, ALU_ADD}, {16'hFF00, 16'h0100}, {16'h0FF0, 16'h0023}, 2'b00);
        for (int i = 0; i < 7; i++)
            applyStimulus(2'b11, {ALU_XOR, ALU_ADD}, {16'hFF00, 16'h0100}, {16'h0FF0, 16'h0023}, 2'b10);
        for (int i = 0; i < 6; i++)
            applyStimulus(2'b11, {ALU_XOR, ALU_ADD}, {16'hFF00, 16'h0100}, {16'h0FF0, 16'h0023}, 2'b11);
        idleCycles(3);

        $display("[TB] operand isolation");
        applyStimulus(2'b01, {3'd0, ALU_ADD}, {16'h0, 16'h1234}, {16'h0, 16'h0001}, 2'b11);
        applyStimulus(2'b00, {3'd0, ALU_SUB}, {16'h0, 16'hFFFF}, {16'h0, 16'hFFFF}, 2'b11);
        idleCycles(3);

        $display("[TB] reset during issue");
        applyStimulus(2'b01, {3'd0, ALU_ADD}, {16'h0, 16'h4000}, {16'h0, 16'h0004}, 2'b11);
        checkOutput("issue_before_reset", 32'(alu_start), 32'd0);
        resetDut();
        for (int i = 0; i < 4; i++)
            applyStimulus(2'b11, {ALU_XOR, ALU_SUB}, {16'hAAAA, 16'd9}, {16'h5555, 16'd2}, 2'b11);
        idleCycles(3);

        $display("[TB] throughput");
        measureGap = 1'b1;
        prevAccept = -1;
        for (int i = 0; i < 14; i++)
            applyStimulus(2'b01, {3'd0, 3'(i)}, {16'h0, 16'(i * 77)}, {16'h0, 16'(i + 1)}, 2'b11);
        measureGap = 1'b0;
        idleCycles(3);

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++)
            applyStimulus(2'($urandom_range(0, 3)), 6'($urandom), $urandom, $urandom,
                          2'($urandom_range(0, 3)));

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
